// File: rtl/prng_word_packer.sv
// rtl/prng_word_packer.sv - packs a serial PRNG bit stream into words behind a small FWFT buffer
// with overflow tracking.

module prng_word_packer #(
    parameter int WORD_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          bit_valid,
    input  logic                          bit_in,
    output logic [WORD_WIDTH-1:0]         word_data,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          overflow,
    output logic [15:0]                   drop_count
);

    localparam int CW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = AW + 1;

    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [WORD_WIDTH-2:0] sr_q, sr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [FW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [15:0]           drops_q, drops_d;
    logic [WORD_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [WORD_WIDTH-1:0] mem_d [FIFO_DEPTH];

    logic [WORD_WIDTH-1:0] word_next;
    logic                  word_done;
    logic                  full;
    logic                  pop;
    logic                  push;
    logic                  drop;

    // The completed word includes the bit arriving on this edge, so it can be
    // pushed without waiting for the shift register to catch up.
    assign word_next = {sr_q, bit_in};
    assign word_done = bit_valid && (bit_cnt_q == CW'(WORD_WIDTH - 1));
    assign full      = (count_q == FW'(FIFO_DEPTH));
    assign pop       = (count_q != '0) && word_ready;
    assign push      = word_done && (!full || pop);
    assign drop      = word_done && full && !pop;

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        sr_d       = sr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drops_d    = drops_q;
        mem_d      = mem_q;

        if (clear) begin
            bit_cnt_d  = '0;
            sr_d       = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            drops_d    = '0;
        end else begin
            if (bit_valid) begin
                sr_d      = word_next[WORD_WIDTH-2:0];
                bit_cnt_d = word_done ? '0 : bit_cnt_q + CW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push) begin
                mem_d[wr_ptr_q] = word_next;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + FW'(1);
            end else if (pop && !push) begin
                count_d = count_q - FW'(1);
            end
            if (drop) begin
                overflow_d = 1'b1;
                if (drops_q != 16'hFFFF) begin
                    drops_d = drops_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt_q  <= '0;
            sr_q       <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drops_q    <= '0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            sr_q       <= sr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drops_q    <= drops_d;
        end
    end

    // Storage needs no reset: stale entries are never visible while count_q is 0.
    always_ff @(posedge clock) begin
        if (!reset) begin
            mem_q <= mem_d;
        end
    end

    assign word_valid = (count_q != '0);
    assign word_data  = word_valid ? mem_q[rd_ptr_q] : '0;
    assign fill_level = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drops_q;

endmodule

// File: tb/tb_prng_word_packer.sv
// tb/tb_prng_word_packer.sv - bench for prng_word_packer against a queue-based reference model.

module tb_prng_word_packer;

    localparam int W = 8;
    localparam int D = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         clear = 1'b0;
    logic         bit_valid = 1'b0;
    logic         bit_in = 1'b0;
    logic [W-1:0] word_data;
    logic         word_valid;
    logic         word_ready = 1'b0;
    logic [2:0]   fill_level;
    logic         overflow;
    logic [15:0]  drop_count;

    prng_word_packer #(.WORD_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .fill_level (fill_level),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    int       m_acc  = 0;
    int       m_cnt  = 0;
    logic [7:0] m_q[$];
    logic     m_ovf  = 1'b0;
    int       m_drops = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_acc = 0;
        m_cnt = 0;
        m_q.delete();
        m_ovf = 1'b0;
        m_drops = 0;
    endtask

    task automatic check_outputs();
        logic [7:0] head;
        head = (m_q.size() > 0) ? m_q[0] : 8'h00;
        check("word_valid", {31'd0, word_valid}, {31'd0, m_q.size() > 0});
        check("word_data",  {24'd0, word_data},  {24'd0, head});
        check("fill_level", {29'd0, fill_level}, m_q.size());
        check("overflow",   {31'd0, overflow},   {31'd0, m_ovf});
        check("drop_count", {16'd0, drop_count}, m_drops);
    endtask

    // One clock: drive away from the edge, advance the model on the edge, check after it.
    task automatic step(input logic rst, input logic clr, input logic bv,
                        input logic bi, input logic rdy);
        bit pop;
        bit done;
        @(negedge clock);
        reset = rst;
        clear = clr;
        bit_valid = bv;
        bit_in = bi;
        word_ready = rdy;
        @(posedge clock);
        if (rst || clr) begin
            model_clear();
        end else begin
            pop = (m_q.size() > 0) && rdy;
            done = 1'b0;
            if (bv) begin
                m_acc = ((m_acc << 1) | int'(bi)) & 8'hFF;
                m_cnt = m_cnt + 1;
                if (m_cnt == W) begin
                    done = 1'b1;
                    m_cnt = 0;
                end
            end
            if (pop) void'(m_q.pop_front());
            if (done) begin
                if (m_q.size() < D) begin
                    m_q.push_back(m_acc[7:0]);
                end else begin
                    m_ovf = 1'b1;
                    if (m_drops < 65535) m_drops = m_drops + 1;
                end
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic send_word(input logic [7:0] w, input logic rdy, input int max_gap);
        logic [7:0] v;
        v = w;
        for (int i = W - 1; i >= 0; i--) begin
            if (max_gap > 0) begin
                int g;
                g = $urandom_range(max_gap, 0);
                for (int k = 0; k < g; k++) step(0, 0, 0, $urandom_range(1, 0), rdy);
            end
            step(0, 0, 1, v[i], rdy);
        end
    endtask

    initial begin
        logic [7:0] b2;
        logic [7:0] a5;
        b2 = 8'hB2;
        a5 = 8'hA5;

        step(1, 0, 1, 1, 1);
        step(1, 0, 0, 0, 0);
        check("reset_word_valid", {31'd0, word_valid}, 32'd0);

        // Back-to-back bits with a ready consumer.
        send_word(8'hB2, 1, 0);
        check("b2_data", {24'd0, word_data}, {24'd0, b2});
        check("b2_valid", {31'd0, word_valid}, 32'd1);
        step(0, 0, 0, 0, 1);
        check("b2_drained", {29'd0, fill_level}, 32'd0);

        // Same word with random gaps must be identical.
        send_word(8'hB2, 0, 3);
        check("b2_gap_data", {24'd0, word_data}, {24'd0, b2});
        step(0, 0, 0, 0, 1);

        // Overflow: fifth word dropped, first four retained in order.
        for (int i = 1; i <= 5; i++) send_word(8'(i), 0, 0);
        check("ovf_fill", {29'd0, fill_level}, 32'd4);
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        check("ovf_drops", {16'd0, drop_count}, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            check("ovf_order", {24'd0, word_data}, i);
            step(0, 0, 0, 0, 1);
        end
        check("ovf_empty", {31'd0, word_valid}, 32'd0);

        // Full FIFO with a pop on the completing edge: no drop.
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) send_word(8'($urandom), 0, 0);
        for (int i = 0; i < W - 1; i++) step(0, 0, 1, $urandom_range(1, 0), 0);
        step(0, 0, 1, 1, 1);
        check("full_pop_fill", {29'd0, fill_level}, 32'd4);
        check("full_pop_ovf", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);

        // Clear with a simultaneous bit discards the partial word.
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0);
        step(0, 1, 1, 1, 0);
        send_word(8'hA5, 0, 0);
        check("clr_a5", {24'd0, word_data}, {24'd0, a5});
        check("clr_fill", {29'd0, fill_level}, 32'd1);
        check("clr_drops", {16'd0, drop_count}, 32'd0);

        // Random traffic including occasional clears.
        for (int i = 0; i < 600; i++) begin
            step(0, ($urandom_range(99, 0) == 0), $urandom_range(3, 0) != 0,
                 $urandom_range(1, 0), $urandom_range(2, 0) == 0);
        end

        // Long run with no consumer.
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 300; i++) send_word(8'($urandom), 0, 0);
        check("drops_296", {16'd0, drop_count}, 32'd296);

        // Saturation: preload the counter, then drop one more word.
        @(negedge clock);
        force dut.drops_q = 16'hFFFF;
        release dut.drops_q;
        m_drops = 65535;
        send_word(8'h3C, 0, 0);
        check("drops_sat", {16'd0, drop_count}, 32'hFFFF);

        step(1, 0, 1, 1, 1);
        check("rst_fill", {29'd0, fill_level}, 32'd0);
        check("rst_drops", {16'd0, drop_count}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_data", {24'd0, word_data}, 32'd0);

        // Reset mid-word: only post-reset bits form the next word.
        for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 0);
        step(1, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0);
        send_word(8'h5A, 0, 1);
        check("rst_mid_word", {24'd0, word_data}, 32'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prng_word_packer.md
PRNG_WORD_PACKER -- requirements
Module: prng_word_packer

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32, output word width; legal range 2..128.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, word buffer entries; legal values are powers of two, at least 2.
REQ-003 SHALL have port clock  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port clear  input  1  synchronous flush of partial word, buffer and statistics.
REQ-006 SHALL have port bit_valid  input  1  qualifies bit_in (PRNG valid).
REQ-007 SHALL have port bit_in  input  1  serial random bit (PRNG lfsr output).
REQ-008 SHALL have port word_data  output  WORD_WIDTH  head-of-buffer word.
REQ-009 SHALL have port word_valid  output  1  buffer non-empty.
REQ-010 SHALL have port word_ready  input  1  consumer accepts word_data.
REQ-011 SHALL have port fill_level  output  $clog2(FIFO_DEPTH)+1  number of buffered words.
REQ-012 SHALL have port overflow  output  1  sticky flag: at least one word dropped.
REQ-013 SHALL have port drop_count  output  16  dropped-word count, saturating.

Function
REQ-014 SHALL shift on every edge with bit_valid=1: shift register becomes {sr[WORD_WIDTH-2:0], bit_in}, so the first received bit ends up as the word MSB.
REQ-015 SHALL count received bits 0..WORD_WIDTH-1; a bit accepted at count WORD_WIDTH-1 completes a word, and the count wraps to 0 on that same edge.
REQ-016 SHALL treat bit_valid=0 cycles as gaps: no shift, no count change; gaps never alter word content.
REQ-017 SHALL push each completed word, {sr[WORD_WIDTH-2:0], bit_in}, into the FIFO on the completing edge when the FIFO is not full.
REQ-018 SHALL allow the push when the FIFO is full and a pop occurs on the same edge; no drop, fill_level unchanged.
REQ-019 SHALL, when the FIFO is full and there is no pop, discard the completed word, set overflow=1, and increment drop_count (saturating at 0xFFFF).
REQ-020 SHALL drive word_valid=1 whenever fill_level>0, with word_data as the oldest word (first-word-fall-through).
REQ-021 SHALL pop on an edge where word_valid=1 and word_ready=1; word_ready while empty SHALL have no effect.
REQ-022 SHALL hold word_data and word_valid stable while word_valid=1 and word_ready=0.
REQ-023 SHALL have 1-cycle latency: a word completed at edge N into an empty FIFO is visible on word_data/word_valid after edge N.
REQ-024 SHALL update fill_level as follows:
  - +1 on push only; -1 on pop only; unchanged on push plus pop.
  - Range 0..FIFO_DEPTH.
  - Buffer states: EMPTY (0), PARTIAL, FULL (FIFO_DEPTH).
REQ-025 SHALL wrap read/write pointers modulo FIFO_DEPTH with no data corruption across the wrap.
REQ-026 SHALL apply clear=1 as follows:
  - Bit count, shift register, FIFO, overflow and drop_count go to 0 on that edge.
  - Any bit_valid, push or pop in the same cycle is discarded.
REQ-027 SHALL give signals priority in the order reset, then clear, then normal operation.

Reset
REQ-028 SHALL, after reset=1 at a rising edge, drive: word_valid=0, word_data=0, fill_level=0, overflow=0, drop_count=0; internal bit count and shift register also 0.
REQ-029 SHALL, on reset mid-word or with a full FIFO, discard all partial and buffered data; the first word after reset is built only from post-reset bits.
REQ-030 SHALL ignore bit_in, bit_valid and word_ready while reset=1.

Verification (WORD_WIDTH=8, FIFO_DEPTH=4)
REQ-031 SHALL cover: bits 1,0,1,1,0,0,1,0 on consecutive cycles, word_ready=1 -> word_data=0xB2 and word_valid=1 the cycle after bit 8; popped next edge; fill_level returns to 0.
REQ-032 SHALL cover: same bits with 0-3 idle cycles inserted randomly between them -> identical word 0xB2.
REQ-033 SHALL cover: word_ready=0, words 0x01,0x02,0x03,0x04,0x05 -> fill_level=4, overflow=1, drop_count=1; then ready=1 -> 0x01..0x04 in order, 0x05 absent.
REQ-034 SHALL cover: FIFO full and word_ready=1 on the cycle a fifth word completes -> no drop; fill_level stays 4; overflow=0.
REQ-035 SHALL cover: 3 bits, then clear=1 together with bit_valid=1, then bits 0xA5 MSB-first -> single word 0xA5; drop_count=0.
REQ-036 SHALL cover: 300 words with ready=0 -> drop_count=296; separately, with drop_count preloaded at 0xFFFF (forced) -> stays 0xFFFF; then reset=1 -> all outputs 0 next cycle.
